// File: rtl/vend_ctrl_mc.sv
// Multi-item vending controller: price table, per-item stock, coin credit, handshaked change.
// Optional macro VEND_CREDIT_CARRY_EN: continue_buy during VEND keeps leftover credit and skips change.
module vend_ctrl_mc #(
  parameter int NUM_ITEMS  = 4,
  parameter int ITEM_W     = $clog2(NUM_ITEMS),
  parameter int MONEY_W    = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 3,
  parameter int DEF_PRICE  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cancel,
  input  logic                 sel_valid,
  input  logic [ITEM_W-1:0]    item_in,
  input  logic                 coin_valid,
  input  logic [1:0]           coin_code,
  input  logic                 done_money,
  input  logic                 continue_buy,
  input  logic                 change_ready,
  input  logic                 price_we,
  input  logic [ITEM_W-1:0]    price_addr,
  input  logic [MONEY_W-1:0]   price_data,
  input  logic                 restock_valid,
  input  logic [ITEM_W-1:0]    restock_item,
  input  logic [STOCK_W-1:0]   restock_qty,
  output logic [2:0]           state,
  output logic                 done,
  output logic                 end_trans,
  output logic                 out_stock,
  output logic                 need_more,
  output logic                 coin_reject,
  output logic [MONEY_W-1:0]   price,
  output logic [MONEY_W-1:0]   sum_money,
  output logic [ITEM_W-1:0]    item_select,
  output logic                 change_valid,
  output logic [1:0]           change_coin,
  output logic [NUM_ITEMS-1:0] stock_empty
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_RECEIVE = 3'd2,
    S_COMPARE = 3'd3,
    S_VEND    = 3'd4,
    S_CHANGE  = 3'd5
  } state_t;

  function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      2'd0:    return MONEY_W'(5);
      2'd1:    return MONEY_W'(10);
      2'd2:    return MONEY_W'(20);
      default: return MONEY_W'(50);
    endcase
  endfunction

  function automatic logic [1:0] largest_coin(input logic [MONEY_W-1:0] amt);
    if (amt >= MONEY_W'(50))      return 2'd3;
    else if (amt >= MONEY_W'(20)) return 2'd2;
    else if (amt >= MONEY_W'(10)) return 2'd1;
    else                          return 2'd0;
  endfunction

  state_t               state_q, state_d;
  logic [MONEY_W-1:0]   sum_q, sum_d;
  logic [MONEY_W-1:0]   price_q, price_d;
  logic [ITEM_W-1:0]    item_q, item_d;
  logic [MONEY_W-1:0]   chg_q, chg_d;
  logic                 done_q, done_d;
  logic                 end_q, end_d;
  logic                 out_stock_q, out_stock_d;
  logic                 need_more_q, need_more_d;
  logic                 coin_rej_q, coin_rej_d;
  logic                 chg_vld_q, chg_vld_d;
  logic [1:0]           chg_coin_q, chg_coin_d;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic [STOCK_W:0]     st_sum  [NUM_ITEMS];
  logic [MONEY_W-1:0]   price_tbl_q [NUM_ITEMS];
  logic [MONEY_W:0]     coin_add;
  logic                 dec_en;
  logic                 item_ok;
  logic                 addr_ok;

  assign item_ok  = (32'(item_in) < NUM_ITEMS);
  assign addr_ok  = (32'(price_addr) < NUM_ITEMS);
  assign coin_add = {1'b0, sum_q} + {1'b0, coin_value(coin_code)};

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    price_d     = price_q;
    item_d      = item_q;
    chg_d       = chg_q;
    end_d       = 1'b0;
    out_stock_d = 1'b0;
    need_more_d = 1'b0;
    coin_rej_d  = 1'b0;
    dec_en      = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_SELECT;
      S_SELECT: begin
        if (cancel) begin
          state_d = S_IDLE;
          sum_d   = '0;
        end else if (sel_valid) begin
          if (!item_ok || stock_q[item_in] == '0) begin
            out_stock_d = 1'b1;
          end else begin
            item_d  = item_in;
            price_d = price_tbl_q[item_in];
            state_d = S_RECEIVE;
          end
        end
      end
      S_RECEIVE: begin
        if (cancel) begin
          state_d = S_CHANGE;
          chg_d   = sum_q;
        end else begin
          // the carry bit flags a coin that would overflow the credit register
          if (coin_valid) begin
            if (coin_add[MONEY_W]) coin_rej_d = 1'b1;
            else                   sum_d      = coin_add[MONEY_W-1:0];
          end
          if (done_money) state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (sum_q >= price_q) begin
          state_d = S_VEND;
        end else begin
          need_more_d = 1'b1;
          state_d     = S_RECEIVE;
        end
      end
      S_VEND: begin
        dec_en = 1'b1;
`ifdef VEND_CREDIT_CARRY_EN
        if (continue_buy) begin
          sum_d   = sum_q - price_q;
          end_d   = 1'b1;
          state_d = S_SELECT;
        end else begin
          chg_d   = sum_q - price_q;
          state_d = S_CHANGE;
        end
`else
        chg_d   = sum_q - price_q;
        state_d = S_CHANGE;
`endif
      end
      S_CHANGE: begin
        // a remainder below the smallest coin is forfeited
        if (chg_q < MONEY_W'(5)) begin
          end_d   = 1'b1;
          sum_d   = '0;
          state_d = continue_buy ? S_SELECT : S_IDLE;
        end else if (chg_vld_q && change_ready) begin
          chg_d = chg_q - coin_value(chg_coin_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d     = (state_d == S_VEND);
    chg_vld_d  = (state_d == S_CHANGE) && (chg_d >= MONEY_W'(5));
    chg_coin_d = chg_vld_d ? largest_coin(chg_d) : 2'd0;
  end

  // restock and vend on the same item net out before saturating
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      st_sum[i] = {1'b0, stock_q[i]};
      if (restock_valid && 32'(restock_item) == i) st_sum[i] = st_sum[i] + {1'b0, restock_qty};
      if (dec_en && 32'(item_q) == i)              st_sum[i] = st_sum[i] - 1'b1;
      stock_d[i] = st_sum[i][STOCK_W] ? '1 : st_sum[i][STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      price_q     <= '0;
      item_q      <= '0;
      chg_q       <= '0;
      done_q      <= 1'b0;
      end_q       <= 1'b0;
      out_stock_q <= 1'b0;
      need_more_q <= 1'b0;
      coin_rej_q  <= 1'b0;
      chg_vld_q   <= 1'b0;
      chg_coin_q  <= 2'd0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i]     <= STOCK_W'(INIT_STOCK);
        price_tbl_q[i] <= MONEY_W'(DEF_PRICE);
      end
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      price_q     <= price_d;
      item_q      <= item_d;
      chg_q       <= chg_d;
      done_q      <= done_d;
      end_q       <= end_d;
      out_stock_q <= out_stock_d;
      need_more_q <= need_more_d;
      coin_rej_q  <= coin_rej_d;
      chg_vld_q   <= chg_vld_d;
      chg_coin_q  <= chg_coin_d;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
      if (state_q == S_IDLE && price_we && addr_ok) price_tbl_q[price_addr] <= price_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) stock_empty[i] = (stock_q[i] == '0);
  end

  assign state        = state_q;
  assign done         = done_q;
  assign end_trans    = end_q;
  assign out_stock    = out_stock_q;
  assign need_more    = need_more_q;
  assign coin_reject  = coin_rej_q;
  assign price        = price_q;
  assign sum_money    = sum_q;
  assign item_select  = item_q;
  assign change_valid = chg_vld_q;
  assign change_coin  = chg_coin_q;

endmodule

// File: doc/vend_ctrl_mc.md
# vend_ctrl_mc

Parametrised multi-item vending controller, next generation of the single-product vending FSM. Handles a configurable item count with a writable price table, per-item stock counters with restock, coin acceptance with overflow rejection, and handshaked change dispensing in real coin denominations. It sits between the coin/keypad front end and the dispenser/coin-return mechanics.

## Interface
- NUM_ITEMS, 4: number of selectable items (≥2)
- ITEM_W, $clog2(NUM_ITEMS): item index width
- MONEY_W, 8: width of credit, price and change arithmetic
- STOCK_W, 4: per-item stock counter width
- INIT_STOCK, 3: stock of every item after reset
- DEF_PRICE, 15: price of every item after reset (multiple of 5)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin transaction (IDLE only)
- cancel  in  1  abort; highest priority in SELECT/RECEIVE
- sel_valid  in  1  item_in valid (SELECT only)
- item_in  in  ITEM_W  requested item
- coin_valid  in  1  one coin presented this cycle
- coin_code  in  2  00=5, 01=10, 10=20, 11=50
- done_money  in  1  customer finished inserting coins
- continue_buy  in  1  start another purchase after this one
- change_ready  in  1  coin-return mechanism accepts change_coin
- price_we, price_addr[ITEM_W], price_data[MONEY_W]  in  price table write
- restock_valid, restock_item[ITEM_W], restock_qty[STOCK_W]  in  stock refill
- state  out  3  IDLE=0, SELECT=1, RECEIVE=2, COMPARE=3, VEND=4, CHANGE=5
- done  out  1  one-cycle vend pulse
- end_trans  out  1  one-cycle end-of-transaction pulse
- out_stock, need_more, coin_reject  out  1 each  one-cycle status pulses
- price  out  MONEY_W  price of latched item
- sum_money  out  MONEY_W  accumulated credit
- item_select  out  ITEM_W  latched item
- change_valid  out  1  change coin offered
- change_coin  out  2  denomination offered (same coding as coin_code)
- stock_empty  out  NUM_ITEMS  bit i = stock[i]==0

## Operation
- Reset: state IDLE; all pulses, change_valid, change_coin, price, sum_money, item_select = 0; stock[i]=INIT_STOCK; price table = DEF_PRICE.
- IDLE: start=1 → SELECT. price_we accepted only in IDLE, ignored elsewhere.
- SELECT: cancel → IDLE (sum_money cleared). sel_valid with item_in ≥ NUM_ITEMS or stock 0 → out_stock pulse, stay. Otherwise latch item_select, price → RECEIVE.
- RECEIVE: coin_valid adds coin value to sum_money; if result > 2^MONEY_W-1, coin not added, coin_reject pulse. cancel → CHANGE with change = sum_money, no vend. done_money → COMPARE; coin in the same cycle is counted first.
- COMPARE (1 cycle): sum_money ≥ price → VEND; else need_more pulse, → RECEIVE.
- VEND (1 cycle): done=1, stock[item_select] decremented, remaining change = sum_money − price → CHANGE.
- CHANGE: while remaining ≥ 5, change_valid=1, change_coin = largest denomination ≤ remaining; on change_valid & change_ready, remaining −= value. Remaining < 5 is forfeited. When nothing left: end_trans pulse, sum_money cleared; continue_buy sampled that cycle → SELECT, else IDLE.
- Restock: any state; stock += restock_qty, saturating at 2^STOCK_W−1. Same-cycle restock and vend decrement on same item: net +qty−1 (saturated).
- reset mid-transaction: immediate return to reset values; coins in flight are lost, change_valid drops asynchronously.

## Timing
- All outputs registered; transitions take effect at the clock edge after the qualifying input.
- start to SELECT: 1 cycle. done_money to done: 2 cycles when credit sufficient.
- change_valid, change_coin stable until accepted; one coin per accepted cycle, back-to-back allowed.
- sum_money reflects a coin one cycle after coin_valid.

## Configuration
- VEND_CREDIT_CARRY_EN defined: continue_buy=1 during the VEND cycle skips CHANGE; sum_money = sum_money − price, end_trans pulses, → SELECT with credit retained.
- Not defined: continue_buy ignored in VEND; change always dispensed and credit cleared.

## Test plan
- reset, start=1 → state IDLE then SELECT after 1 cycle; all outputs 0, stock_empty=0.
- SELECT item 1, coins 10+10, done_money → COMPARE, VEND (done=1), CHANGE offers coin 5 once; change_ready=1 → end_trans, IDLE, stock[1]=2.
- Item 0 price 15, coin 5, done_money → need_more pulse, back to RECEIVE; coin 10, done_money → vend, no change coin.
- Vend item 2 three times → stock_empty[2]=1; selecting item 2 → out_stock pulse, stays SELECT; restock qty 5 → selectable again, stock 5.
- sum_money 240, coin 50 → coin_reject, sum stays 240; cancel → change coins 50×4, 20×2 offered in order, then end_trans.
- With VEND_CREDIT_CARRY_EN: insert 50 for price 15, continue_buy=1 at VEND → SELECT with sum_money=35, no change_valid.
